// File: rtl/pic_pkg.sv
// Shared definitions for the 8259A-style interrupt controller blocks.
// Holds the resolver FSM encoding and the fixed level constants.
package pic_pkg;

  localparam int NUM_IR = 8;
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;
  localparam logic [2:0] LOWEST_PRIO_RESET = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACK2    = 2'd2
  } pr_state_t;

endpackage

// File: rtl/rotating_priority_encoder.sv
// Finds the highest-priority set bit of an 8-bit vector when the level
// after lowest_prio is the most important one (rank 0).
module rotating_priority_encoder
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] vec,
  input  logic [2:0]        lowest_prio,
  output logic              found,
  output logic [2:0]        level,
  output logic [2:0]        rank
);

  logic [NUM_IR-1:0] rotated;

  // rotated[r] is the request bit of the level holding rank r
  for (genvar gi = 0; gi < NUM_IR; gi++) begin : g_rot
    logic [2:0] src;
    assign src         = lowest_prio + 3'(gi + 1);
    assign rotated[gi] = vec[src];
  end

  always_comb begin
    found = 1'b0;
    rank  = 3'd0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found = 1'b1;
        rank  = 3'(i);
      end
    end
  end

  assign level = lowest_prio + rank + 3'd1;

endmodule

// File: rtl/priority_resolver.sv
// Priority resolver and in-service register of the PIC: picks the winning
// request, runs the two-pulse INTA handshake and handles EOI/rotation.
module priority_resolver
  import pic_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  risedBits,
  input  logic        inta,
  input  logic        autoEoi,
  input  logic        rotateOnEoi,
  input  logic        eoi,
  input  logic        specificEoi,
  input  logic [2:0]  eoiLevel,
  input  logic        setPriority,
  input  logic [2:0]  priorityLevel,
  output logic        intReq,
  output logic [2:0]  resetIRR,
  output logic        resetIRRValid,
  output logic [2:0]  vectorIndex,
  output logic        vectorValid,
  output logic [7:0]  inServiceReg
);

  pr_state_t   state_reg, state_next;
  logic [2:0]  lowest_prio_reg, lowest_prio_next;
  logic [2:0]  winner_reg, winner_next;
  logic        spurious_reg, spurious_next;
  logic [7:0]  isr_next;

  logic        req_found, isr_found;
  logic [2:0]  req_level, isr_level, req_rank, isr_rank;
  logic        cand_valid;

  logic [7:0]  set_mask, aeoi_clr, clr_mask;
  logic        rirr_pulse, vec_pulse, aeoi_rotate;

  rotating_priority_encoder u_req_enc (
    .vec         (risedBits),
    .lowest_prio (lowest_prio_reg),
    .found       (req_found),
    .level       (req_level),
    .rank        (req_rank)
  );

  rotating_priority_encoder u_isr_enc (
    .vec         (inServiceReg),
    .lowest_prio (lowest_prio_reg),
    .found       (isr_found),
    .level       (isr_level),
    .rank        (isr_rank)
  );

  // Fully nested: only a strictly higher priority may interrupt service
  assign cand_valid = req_found && (!isr_found || (req_rank < isr_rank));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      lowest_prio_reg <= LOWEST_PRIO_RESET;
      winner_reg      <= 3'd0;
      spurious_reg    <= 1'b0;
      inServiceReg    <= 8'h00;
      intReq          <= 1'b0;
      resetIRR        <= 3'd0;
      resetIRRValid   <= 1'b0;
      vectorIndex     <= 3'd0;
      vectorValid     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      lowest_prio_reg <= lowest_prio_next;
      winner_reg      <= winner_next;
      spurious_reg    <= spurious_next;
      inServiceReg    <= isr_next;
      intReq          <= (state_next != IDLE);
      resetIRRValid   <= rirr_pulse;
      vectorValid     <= vec_pulse;
      if (rirr_pulse) resetIRR <= winner_next;
      if (vec_pulse) vectorIndex <= winner_reg;
    end
  end

  always_comb begin
    state_next    = state_reg;
    winner_next   = winner_reg;
    spurious_next = spurious_reg;
    set_mask      = 8'h00;
    aeoi_clr      = 8'h00;
    rirr_pulse    = 1'b0;
    vec_pulse     = 1'b0;
    aeoi_rotate   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cand_valid) state_next = PENDING;
      end
      PENDING: begin
        if (inta) begin
          state_next = ACK2;
          if (cand_valid) begin
            winner_next         = req_level;
            spurious_next       = 1'b0;
            set_mask[req_level] = 1'b1;
            rirr_pulse          = 1'b1;
          end else begin
            winner_next   = SPURIOUS_LEVEL;
            spurious_next = 1'b1;
          end
        end else if (!cand_valid) begin
          state_next = IDLE;
        end
      end
      ACK2: begin
        if (inta) begin
          state_next = IDLE;
          vec_pulse  = 1'b1;
          if (autoEoi && !spurious_reg) begin
            aeoi_clr[winner_reg] = 1'b1;
            aeoi_rotate          = rotateOnEoi;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    clr_mask         = aeoi_clr;
    lowest_prio_next = lowest_prio_reg;
    if (specificEoi) begin
      clr_mask[eoiLevel] = 1'b1;
    end else if (eoi && isr_found) begin
      clr_mask[isr_level] = 1'b1;
    end
    // An explicit priority write overrides any rotation from an EOI
    if (setPriority) begin
      lowest_prio_next = priorityLevel;
    end else if (specificEoi && rotateOnEoi) begin
      lowest_prio_next = eoiLevel;
    end else if (eoi && isr_found && rotateOnEoi) begin
      lowest_prio_next = isr_level;
    end else if (aeoi_rotate) begin
      lowest_prio_next = winner_reg;
    end
    isr_next = (inServiceReg & ~clr_mask) | set_mask;
  end

endmodule

// File: tb/tb_priority_resolver.sv
// Cycle-by-cycle vector bench for priority_resolver: each row drives one
// cycle of inputs and lists the registered outputs expected after that edge.
module tb_priority_resolver;

  logic       clk = 1'b0;
  logic       reset, inta, autoEoi, rotateOnEoi, eoi, specificEoi, setPriority;
  logic [7:0] risedBits;
  logic [2:0] eoiLevel, priorityLevel;
  logic       intReq, resetIRRValid, vectorValid;
  logic [2:0] resetIRR, vectorIndex;
  logic [7:0] inServiceReg;

  int checks = 0;
  int passed = 0;

  localparam int unsigned RST = 1, ACK = 2, AEOI = 4, ROT = 8, EOI = 16, SEOI = 32, SETP = 64;

  typedef struct packed {
    logic       rst;
    logic [7:0] rb;
    logic       inta, aeoi, rot, eoi, seoi, setp;
    logic [2:0] lvl;
    logic       x_int;
    logic [2:0] x_rirr;
    logic       x_rv;
    logic [2:0] x_vidx;
    logic       x_vv;
    logic [7:0] x_isr;
  } vec_t;

  vec_t rows[$];

  always #5 clk = ~clk;

  priority_resolver dut (
    .clk           (clk),
    .reset         (reset),
    .risedBits     (risedBits),
    .inta          (inta),
    .autoEoi       (autoEoi),
    .rotateOnEoi   (rotateOnEoi),
    .eoi           (eoi),
    .specificEoi   (specificEoi),
    .eoiLevel      (eoiLevel),
    .setPriority   (setPriority),
    .priorityLevel (priorityLevel),
    .intReq        (intReq),
    .resetIRR      (resetIRR),
    .resetIRRValid (resetIRRValid),
    .vectorIndex   (vectorIndex),
    .vectorValid   (vectorValid),
    .inServiceReg  (inServiceReg)
  );

  function automatic vec_t row(input int unsigned ctl, input logic [7:0] rb, input logic [2:0] lvl,
                               input logic x_int, input logic [2:0] x_rirr, input logic x_rv,
                               input logic [2:0] x_vidx, input logic x_vv, input logic [7:0] x_isr);
    vec_t v;
    v.rst  = ctl[0];
    v.inta = ctl[1];
    v.aeoi = ctl[2];
    v.rot  = ctl[3];
    v.eoi  = ctl[4];
    v.seoi = ctl[5];
    v.setp = ctl[6];
    v.rb   = rb;
    v.lvl  = lvl;
    v.x_int  = x_int;
    v.x_rirr = x_rirr;
    v.x_rv   = x_rv;
    v.x_vidx = x_vidx;
    v.x_vv   = x_vv;
    v.x_isr  = x_isr;
    return v;
  endfunction

  task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL row %0d %s: got %0h expected %0h", id, nm, act, exp);
  endtask

  task automatic apply(input vec_t v, input int id);
    reset         = v.rst;
    risedBits     = v.rb;
    inta          = v.inta;
    autoEoi       = v.aeoi;
    rotateOnEoi   = v.rot;
    eoi           = v.eoi;
    specificEoi   = v.seoi;
    setPriority   = v.setp;
    eoiLevel      = v.lvl;
    priorityLevel = v.lvl;
    @(posedge clk);
    #1;
    $display("row %0d: rb=%02h ctl{i%0b e%0b s%0b p%0b} -> int=%0b rirr=%0d/%0b vidx=%0d/%0b isr=%02h",
             id, v.rb, v.inta, v.eoi, v.seoi, v.setp, intReq, resetIRR, resetIRRValid,
             vectorIndex, vectorValid, inServiceReg);
    chk("intReq",        id, {7'd0, intReq},        {7'd0, v.x_int});
    chk("resetIRR",      id, {5'd0, resetIRR},      {5'd0, v.x_rirr});
    chk("resetIRRValid", id, {7'd0, resetIRRValid}, {7'd0, v.x_rv});
    chk("vectorIndex",   id, {5'd0, vectorIndex},   {5'd0, v.x_vidx});
    chk("vectorValid",   id, {7'd0, vectorValid},   {7'd0, v.x_vv});
    chk("inServiceReg",  id, inServiceReg,          v.x_isr);
  endtask

  initial begin
    //                ctl          rb     lvl   int rirr rv vidx vv isr
    rows.push_back(row(RST,        8'h00, 3'd0, 0, 3'd0, 0, 3'd0, 0, 8'h00)); // 0 reset
    rows.push_back(row(0,          8'h24, 3'd0, 1, 3'd0, 0, 3'd0, 0, 8'h00)); // 1 basic ack
    rows.push_back(row(ACK,        8'h24, 3'd0, 1, 3'd2, 1, 3'd0, 0, 8'h04));
    rows.push_back(row(ACK,        8'h20, 3'd0, 0, 3'd2, 0, 3'd2, 1, 8'h04));
    rows.push_back(row(EOI,        8'h00, 3'd0, 0, 3'd2, 0, 3'd2, 0, 8'h00));
    rows.push_back(row(0,          8'h10, 3'd0, 1, 3'd2, 0, 3'd2, 0, 8'h00)); // 5 nesting
    rows.push_back(row(ACK,        8'h10, 3'd0, 1, 3'd4, 1, 3'd2, 0, 8'h10));
    rows.push_back(row(ACK,        8'h00, 3'd0, 0, 3'd4, 0, 3'd4, 1, 8'h10));
    rows.push_back(row(0,          8'h20, 3'd0, 0, 3'd4, 0, 3'd4, 0, 8'h10));
    rows.push_back(row(0,          8'h20, 3'd0, 0, 3'd4, 0, 3'd4, 0, 8'h10));
    rows.push_back(row(0,          8'h01, 3'd0, 1, 3'd4, 0, 3'd4, 0, 8'h10)); // 10
    rows.push_back(row(ACK,        8'h01, 3'd0, 1, 3'd0, 1, 3'd4, 0, 8'h11));
    rows.push_back(row(ACK,        8'h00, 3'd0, 0, 3'd0, 0, 3'd0, 1, 8'h11));
    rows.push_back(row(EOI,        8'h00, 3'd0, 0, 3'd0, 0, 3'd0, 0, 8'h10));
    rows.push_back(row(EOI,        8'h00, 3'd0, 0, 3'd0, 0, 3'd0, 0, 8'h00));
    rows.push_back(row(ROT,        8'h08, 3'd0, 1, 3'd0, 0, 3'd0, 0, 8'h00)); // 15 rotation
    rows.push_back(row(ROT|ACK,    8'h08, 3'd0, 1, 3'd3, 1, 3'd0, 0, 8'h08));
    rows.push_back(row(ROT|ACK,    8'h00, 3'd0, 0, 3'd3, 0, 3'd3, 1, 8'h08));
    rows.push_back(row(ROT|EOI,    8'h00, 3'd0, 0, 3'd3, 0, 3'd3, 0, 8'h00));
    rows.push_back(row(0,          8'h14, 3'd0, 1, 3'd3, 0, 3'd3, 0, 8'h00));
    rows.push_back(row(ACK,        8'h14, 3'd0, 1, 3'd4, 1, 3'd3, 0, 8'h10)); // 20 IR4 wins
    rows.push_back(row(ACK,        8'h04, 3'd0, 0, 3'd4, 0, 3'd4, 1, 8'h10));
    rows.push_back(row(EOI,        8'h00, 3'd0, 0, 3'd4, 0, 3'd4, 0, 8'h00));
    rows.push_back(row(SETP,       8'h00, 3'd7, 0, 3'd4, 0, 3'd4, 0, 8'h00));
    rows.push_back(row(0,          8'h14, 3'd0, 1, 3'd4, 0, 3'd4, 0, 8'h00));
    rows.push_back(row(ACK,        8'h14, 3'd0, 1, 3'd2, 1, 3'd4, 0, 8'h04)); // 25 IR2 wins
    rows.push_back(row(ACK,        8'h10, 3'd0, 0, 3'd2, 0, 3'd2, 1, 8'h04));
    rows.push_back(row(EOI,        8'h10, 3'd0, 0, 3'd2, 0, 3'd2, 0, 8'h00));
    rows.push_back(row(0,          8'h00, 3'd0, 0, 3'd2, 0, 3'd2, 0, 8'h00));
    rows.push_back(row(0,          8'h08, 3'd0, 1, 3'd2, 0, 3'd2, 0, 8'h00)); // 29 spurious
    rows.push_back(row(ACK,        8'h00, 3'd0, 1, 3'd2, 0, 3'd2, 0, 8'h00));
    rows.push_back(row(ACK,        8'h00, 3'd0, 0, 3'd2, 0, 3'd7, 1, 8'h00));
    rows.push_back(row(0,          8'h00, 3'd0, 0, 3'd2, 0, 3'd7, 0, 8'h00));
    rows.push_back(row(AEOI,       8'h80, 3'd0, 1, 3'd2, 0, 3'd7, 0, 8'h00)); // 33 AEOI
    rows.push_back(row(AEOI|ACK,   8'h80, 3'd0, 1, 3'd7, 1, 3'd7, 0, 8'h80));
    rows.push_back(row(AEOI|ACK,   8'h00, 3'd0, 0, 3'd7, 0, 3'd7, 1, 8'h00));
    rows.push_back(row(0,          8'h02, 3'd0, 1, 3'd7, 0, 3'd7, 0, 8'h00)); // 36 withdraw
    rows.push_back(row(0,          8'h00, 3'd0, 0, 3'd7, 0, 3'd7, 0, 8'h00));

    foreach (rows[i]) apply(rows[i], i);

    // Reset in ACK2 after moving priority: afterwards IR0 must be highest again
    apply(row(SETP, 8'h00, 3'd0, 0, 3'd7, 0, 3'd7, 0, 8'h00), 100);
    apply(row(0,    8'h03, 3'd0, 1, 3'd7, 0, 3'd7, 0, 8'h00), 101);
    apply(row(ACK,  8'h03, 3'd0, 1, 3'd1, 1, 3'd7, 0, 8'h02), 102);
    apply(row(RST|ACK, 8'h01, 3'd0, 0, 3'd0, 0, 3'd0, 0, 8'h00), 103);
    apply(row(ACK,  8'h00, 3'd0, 0, 3'd0, 0, 3'd0, 0, 8'h00), 104);
    apply(row(0,    8'h03, 3'd0, 1, 3'd0, 0, 3'd0, 0, 8'h00), 105);
    apply(row(ACK,  8'h03, 3'd0, 1, 3'd0, 1, 3'd0, 0, 8'h01), 106);
    apply(row(ACK,  8'h02, 3'd0, 0, 3'd0, 0, 3'd0, 1, 8'h01), 107);
    apply(row(EOI,  8'h00, 3'd0, 0, 3'd0, 0, 3'd0, 0, 8'h00), 108);

    // Build ISR = 8'h21, then eoi + specificEoi(5): only IR5 clears
    apply(row(0,    8'h20, 3'd0, 1, 3'd0, 0, 3'd0, 0, 8'h00), 200);
    apply(row(ACK,  8'h20, 3'd0, 1, 3'd5, 1, 3'd0, 0, 8'h20), 201);
    apply(row(ACK,  8'h00, 3'd0, 0, 3'd5, 0, 3'd5, 1, 8'h20), 202);
    apply(row(0,    8'h01, 3'd0, 1, 3'd5, 0, 3'd5, 0, 8'h20), 203);
    apply(row(ACK,  8'h01, 3'd0, 1, 3'd0, 1, 3'd5, 0, 8'h21), 204);
    apply(row(ACK,  8'h00, 3'd0, 0, 3'd0, 0, 3'd0, 1, 8'h21), 205);
    apply(row(EOI|SEOI, 8'h00, 3'd5, 0, 3'd0, 0, 3'd0, 0, 8'h01), 206);
    apply(row(EOI,  8'h00, 3'd0, 0, 3'd0, 0, 3'd0, 0, 8'h00), 207);
    apply(row(EOI,  8'h00, 3'd0, 0, 3'd0, 0, 3'd0, 0, 8'h00), 208);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
